// File: rtl/dm_pkg.sv
// Shared definitions for the sized data memory: RV32I size codes, FSM states,
// and helpers that decode an access into lane enables and a legality flag.
package dm_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      ST_CLEAR,
      ST_IDLE
   } state_t;

   function automatic logic [3:0] byteEnable(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] be;
      case (size)
         2'b00:   be = 4'b0001 << off;
         2'b01:   be = 4'b0011 << off;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Unsigned size codes only make sense for loads, so stores reject funct3[2]=1.
   function automatic logic accessLegal(input logic isStore, input logic [2:0] f3,
                                        input logic [1:0] off);
      logic ok;
      case (f3)
         F3_B, F3_BU: ok = 1'b1;
         F3_H, F3_HU: ok = ~off[0];
         F3_W:        ok = (off == 2'b00);
         default:     ok = 1'b0;
      endcase
      if (isStore && f3[2]) ok = 1'b0;
      return ok;
   endfunction

endpackage

// File: rtl/dm_sized_if.sv
// Request/response bundle between the memory stage and the data memory.
interface dm_sized_if #(parameter int ADDR_W = 5) ();

   logic              req;
   logic              we;
   logic [ADDR_W+1:0] addr;
   logic [2:0]        funct3;
   logic [31:0]       wd;
   logic [31:0]       rd;
   logic              rvalid;
   logic              misalign;
   logic              busy;

   modport master (output req, we, addr, funct3, wd,
                   input  rd, rvalid, misalign, busy);

   modport slave  (input  req, we, addr, funct3, wd,
                   output rd, rvalid, misalign, busy);

endinterface

// File: rtl/dm_load_ext.sv
// Selects the addressed lane of a loaded word and sign/zero extends it to 32 bits.
module dm_load_ext
   import dm_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [31:0] shifted;

   assign shifted = word >> {off, 3'b000};

   always_comb begin
      result = '0;
      case (funct3)
         F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   result = {24'h0, shifted[7:0]};
         F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   result = {16'h0, shifted[15:0]};
         F3_W:    result = shifted;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/dm_sized.sv
// RV32I data memory: sized stores with lane enables, extended loads, misalignment
// reporting, and an optional zero-fill sweep of the array after reset.
module dm_sized
   import dm_pkg::*;
#(
   parameter int ADDR_W         = 5,
   parameter int DATA_W         = 32,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic     clk,
   input  logic     rst,
   dm_sized_if.slave bus
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state;
   state_t            stateNext;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] widx;
   logic [1:0]        off;
   logic              accept;
   logic              legal;
   logic [3:0]        be;
   logic [31:0]       wlanes;
   logic [31:0]       loadVal;

   assign widx     = bus.addr[ADDR_W+1:2];
   assign off      = bus.addr[1:0];
   assign accept   = bus.req && (state == ST_IDLE);
   assign legal    = accessLegal(bus.we, bus.funct3, off);
   assign be       = byteEnable(bus.funct3[1:0], off);
   assign bus.busy = (state == ST_CLEAR);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      else      state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         ST_CLEAR: if (ptr == ADDR_W'(DEPTH - 1)) stateNext = ST_IDLE;
         ST_IDLE:  stateNext = ST_IDLE;
         default:  stateNext = ST_IDLE;
      endcase
   end

   // The pointer wraps back to zero as the sweep finishes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                   ptr <= '0;
      else if (state == ST_CLEAR) ptr <= ptr + 1'b1;
   end

   // Replicate narrow store data across lanes so each enabled lane picks its own copy.
   always_comb begin
      wlanes = bus.wd;
      case (bus.funct3[1:0])
         2'b00:   wlanes = {4{bus.wd[7:0]}};
         2'b01:   wlanes = {2{bus.wd[15:0]}};
         default: wlanes = bus.wd;
      endcase
   end

   always_ff @(posedge clk) begin
      if (state == ST_CLEAR) begin
         mem[ptr] <= '0;
      end else if (accept && legal && bus.we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[widx][8*i +: 8] <= wlanes[8*i +: 8];
         end
      end
   end

   dm_load_ext u_load_ext (
      .word   (mem[widx]),
      .off    (off),
      .funct3 (bus.funct3),
      .result (loadVal)
   );

   // rd only moves on a completed load or a dropped access; stores leave it alone.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.rd       <= '0;
         bus.rvalid   <= 1'b0;
         bus.misalign <= 1'b0;
      end else begin
         bus.rvalid   <= accept;
         bus.misalign <= accept && !legal;
         if (accept && !legal)        bus.rd <= '0;
         else if (accept && !bus.we)  bus.rd <= loadVal;
      end
   end

endmodule

// File: tb/tb_dm_sized.sv
// Self-checking bench for dm_sized: directed steps plus random accesses checked
// against a byte-array model of little-endian sized loads and stores.
module tb_dm_sized;

   logic clk;
   logic rst;

   dm_sized_if #(.ADDR_W(5)) bus ();

   dm_sized #(.ADDR_W(5), .DATA_W(32), .CLEAR_ON_RESET(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checkCount = 0;
   int          passCount  = 0;
   logic [7:0]  modelMem [128];
   logic [31:0] expRd;
   bit          expMis;
   bit          sawValid;
   int          cycles;
   logic [31:0] tpExp [4];

   task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
   endtask

   task automatic modelClear();
      for (int i = 0; i < 128; i++) modelMem[i] = 8'h00;
   endtask

   // Reference behaviour computed from byte addresses and access sizes.
   task automatic modelAccess(input bit isStore, input logic [6:0] a, input logic [2:0] f3,
                              input logic [31:0] w, output bit mis);
      int          n;
      bit          ok;
      logic [31:0] val;
      n  = 1 << f3[1:0];
      ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)
           && (int'(a) % n == 0) && !(isStore && f3 > 3'd2);
      if (!ok) begin
         mis   = 1'b1;
         expRd = 32'h0;
      end else if (isStore) begin
         mis = 1'b0;
         for (int k = 0; k < n; k++) modelMem[int'(a) + k] = w[8*k +: 8];
      end else begin
         mis = 1'b0;
         val = 32'h0;
         for (int k = 0; k < n; k++) val = val | (32'(modelMem[int'(a) + k]) << (8 * k));
         if (f3 < 3'd2 && val[8*n-1]) val = val - (32'd1 << (8 * n));
         expRd = val;
      end
   endtask

   task automatic checkOutput(input string tag, input bit mis);
      checkEq({tag, ".rvalid"}, 32'(bus.rvalid), 32'd1);
      checkEq({tag, ".misalign"}, 32'(bus.misalign), 32'(mis));
      checkEq({tag, ".rd"}, bus.rd, expRd);
   endtask

   task automatic applyStimulus(input string tag, input bit isStore, input logic [6:0] a,
                                input logic [2:0] f3, input logic [31:0] w);
      bit mis;
      modelAccess(isStore, a, f3, w, mis);
      @(negedge clk);
      bus.req    = 1'b1;
      bus.we     = isStore;
      bus.addr   = a;
      bus.funct3 = f3;
      bus.wd     = w;
      @(posedge clk);
      #1;
      bus.req = 1'b0;
      checkOutput(tag, mis);
   endtask

   task automatic countBusy(output int n, inout bit seen);
      n = 0;
      while (bus.busy && n < 200) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.rvalid) seen = 1'b1;
      end
   endtask

   initial begin
      rst        = 1'b0;
      bus.req    = 1'b0;
      bus.we     = 1'b0;
      bus.addr   = '0;
      bus.funct3 = 3'b010;
      bus.wd     = '0;
      expRd      = 32'h0;
      #22;
      checkEq("reset.rd", bus.rd, 32'h0);
      checkEq("reset.rvalid", 32'(bus.rvalid), 32'd0);
      checkEq("reset.misalign", 32'(bus.misalign), 32'd0);
      checkEq("reset.busy", 32'(bus.busy), 32'd1);

      $display("[TB] clear after reset with req held high");
      @(negedge clk);
      bus.req    = 1'b1;
      bus.we     = 1'b1;
      bus.addr   = 7'h04;
      bus.funct3 = 3'b010;
      bus.wd     = 32'hFFFF_FFFF;
      rst        = 1'b1;
      modelClear();
      sawValid = 1'b0;
      countBusy(cycles, sawValid);
      bus.req = 1'b0;
      checkEq("clear.cycles", 32'(cycles), 32'd32);
      checkEq("clear.noValid", 32'(sawValid), 32'd0);
      applyStimulus("clear.lw0C", 1'b0, 7'h0C, 3'b010, 32'h0);
      applyStimulus("clear.lw04", 1'b0, 7'h04, 3'b010, 32'h0);

      $display("[TB] sized loads");
      applyStimulus("sw08", 1'b1, 7'h08, 3'b010, 32'h80FF_7F01);
      checkEq("sw08.rdHeld", bus.rd, 32'h0);
      applyStimulus("lb08", 1'b0, 7'h08, 3'b000, 32'h0);
      checkEq("lb08.value", bus.rd, 32'h0000_0001);
      applyStimulus("lb0A", 1'b0, 7'h0A, 3'b000, 32'h0);
      checkEq("lb0A.value", bus.rd, 32'hFFFF_FFFF);
      applyStimulus("lbu0A", 1'b0, 7'h0A, 3'b100, 32'h0);
      checkEq("lbu0A.value", bus.rd, 32'h0000_00FF);
      applyStimulus("lh0A", 1'b0, 7'h0A, 3'b001, 32'h0);
      checkEq("lh0A.value", bus.rd, 32'hFFFF_80FF);
      applyStimulus("lhu0A", 1'b0, 7'h0A, 3'b101, 32'h0);
      checkEq("lhu0A.value", bus.rd, 32'h0000_80FF);
      applyStimulus("lw08", 1'b0, 7'h08, 3'b010, 32'h0);
      checkEq("lw08.value", bus.rd, 32'h80FF_7F01);

      $display("[TB] partial stores");
      applyStimulus("sb09", 1'b1, 7'h09, 3'b000, 32'h1234_56AA);
      applyStimulus("sh0A", 1'b1, 7'h0A, 3'b001, 32'hDEAD_BEEF);
      applyStimulus("lw08b", 1'b0, 7'h08, 3'b010, 32'h0);
      checkEq("lw08b.value", bus.rd, 32'hBEEF_AA01);

      $display("[TB] misalignment");
      applyStimulus("lw06", 1'b0, 7'h06, 3'b010, 32'h0);
      checkEq("lw06.zero", bus.rd, 32'h0);
      applyStimulus("lw00pre", 1'b0, 7'h00, 3'b010, 32'h0);
      applyStimulus("sh03", 1'b1, 7'h03, 3'b001, 32'h0000_FFFF);
      applyStimulus("lw00post", 1'b0, 7'h00, 3'b010, 32'h0);
      applyStimulus("f3_011", 1'b0, 7'h08, 3'b011, 32'h0);
      applyStimulus("sbu_store", 1'b1, 7'h10, 3'b100, 32'h55);
      applyStimulus("lw10", 1'b0, 7'h10, 3'b010, 32'h0);

      $display("[TB] back-to-back loads");
      for (int i = 0; i < 4; i++) begin
         modelAccess(1'b0, 7'(4 * i + 8), 3'b010, 32'h0, expMis);
         tpExp[i] = expRd;
         @(negedge clk);
         bus.req    = 1'b1;
         bus.we     = 1'b0;
         bus.addr   = 7'(4 * i + 8);
         bus.funct3 = 3'b010;
         @(posedge clk);
         #1;
         checkEq($sformatf("tp%0d.rvalid", i), 32'(bus.rvalid), 32'd1);
         checkEq($sformatf("tp%0d.rd", i), bus.rd, tpExp[i]);
      end
      @(negedge clk);
      bus.req = 1'b0;
      @(posedge clk);
      #1;
      checkEq("tp.idleValid", 32'(bus.rvalid), 32'd0);

      $display("[TB] random accesses");
      for (int i = 0; i < 150; i++) begin
         applyStimulus($sformatf("rnd%0d", i), 1'($urandom % 2), 7'($urandom_range(0, 127)),
                       3'($urandom_range(0, 7)), $urandom);
      end

      $display("[TB] reset in the middle of a clear");
      @(negedge clk);
      rst = 1'b0;
      #2;
      rst = 1'b1;
      modelClear();
      bus.req    = 1'b1;
      bus.we     = 1'b1;
      bus.addr   = 7'h14;
      bus.funct3 = 3'b010;
      bus.wd     = 32'hA5A5_A5A5;
      sawValid   = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (bus.rvalid) sawValid = 1'b1;
      end
      rst = 1'b0;
      #3;
      checkEq("midclr.busyInReset", 32'(bus.busy), 32'd1);
      checkEq("midclr.rvalidInReset", 32'(bus.rvalid), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      countBusy(cycles, sawValid);
      bus.req = 1'b0;
      checkEq("midclr.cycles", 32'(cycles), 32'd32);
      checkEq("midclr.noValid", 32'(sawValid), 32'd0);
      applyStimulus("midclr.lw14", 1'b0, 7'h14, 3'b010, 32'h0);
      applyStimulus("midclr.lw7C", 1'b0, 7'h7C, 3'b010, 32'h0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/dm_sized.md
Name: dm_sized

Overview:
Parametrised RV32I data memory with byte/halfword/word access, sized loads with sign/zero extension, and misalignment detection. It uses a single-port synchronous array with a registered read and a one-cycle request/valid handshake. After reset it runs a clear sequence that zero-fills the whole array. It sits in the memory stage between the ALU address output and the write-back mux.

Parameters:
ADDR_W, 5, word-address bits; DEPTH = 2**ADDR_W words
DATA_W, 32, word width; fixed at 32 (RV32I), kept for package use
CLEAR_ON_RESET, 1, 1 = zero-fill array after reset; 0 = skip clear, ready immediately

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
req  in  1  access request, sampled on clk when busy=0
we  in  1  1 = store, 0 = load
addr  in  ADDR_W+2  byte address; [ADDR_W+1:2] word index, [1:0] byte offset
funct3  in  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
wd  in  32  store data; the low bytes are used for SB/SH
rd  out  32  load result, extended to 32 bits
rvalid  out  1  one-cycle pulse: result of the accepted access is on rd/misalign
misalign  out  1  qualified by rvalid: the access was illegal or misaligned and was dropped
busy  out  1  clear sequence in progress; requests are ignored

Behaviour:
- Reset (rst=0, asynchronous): rd=0, rvalid=0, misalign=0, clear pointer=0.
  - busy=1 and state=CLEAR if CLEAR_ON_RESET=1.
  - busy=0 and state=IDLE otherwise.
  - Array contents are not reset directly.
- FSM states: CLEAR, IDLE.
  - CLEAR: each cycle writes 0 to memory[ptr] and increments ptr. When ptr=DEPTH-1 is written, go to IDLE and drop busy next cycle. The clear takes exactly DEPTH cycles after rst deasserts.
  - Reset asserted mid-clear restarts the clear from ptr=0.
- Accept rule: the access is accepted when req=1 and state=IDLE at the clk edge. req during CLEAR is ignored: no write, no rvalid, and no queuing.
- Legality, with off=addr[1:0]:
  - B/BU: any off.
  - H/HU: off[0]=0.
  - W: off=00.
  - funct3 of 011, 110 or 111 is illegal. Stores accept only 000, 001 and 010; any other store code is illegal.
- Illegal or misaligned access: the array is unchanged. Next cycle rvalid=1, misalign=1, rd=0.
- Store (legal): the write happens at the accepting edge, using byte enables derived from size and off.
  - SB: wd[7:0] goes to lane off.
  - SH: wd[15:0] goes to lanes off and off+1.
  - SW: all four lanes.
  - Next cycle rvalid=1, misalign=0; rd is unchanged.
- Load (legal): the word is read at the accepting edge. The lane is shifted right by off*8, then extended.
  - B: sign bit 7. BU: zero-extend.
  - H: sign bit 15. HU: zero-extend.
  - W: as-is.
  - Result is registered: rd is valid with rvalid=1, misalign=0, one cycle after acceptance.
- Back-to-back: a store at cycle N followed by a load of the same word at N+1 returns the new data. There are no read-during-write hazards, because there is one access per cycle.
- rvalid and misalign are single-cycle pulses; continuous req gives one pulse per accepted cycle. rd holds its last value until the next completed load or misaligned access.
- Little-endian byte ordering within each word.

Decomposition:
- Package dm_pkg:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - state enum (ST_CLEAR, ST_IDLE).
  - function returning the 4-bit byte-enable from size and offset.
- Sub-module dm_load_ext: combinational lane select plus sign/zero extension (word, off, funct3 -> 32-bit result). It is reused later by the cache path.

Test Plan:
- Clear after reset: release rst; busy=1 for 32 cycles (ADDR_W=5). Then LW 0x0C -> rvalid=1, rd=0x00000000, misalign=0.
- Sized loads: SW 0x80FF7F01 @0x08, then:
  - LB @0x08 -> 0x00000001
  - LB @0x0A -> 0xFFFFFFFF
  - LBU @0x0A -> 0x000000FF
  - LH @0x0A -> 0xFFFF80FF
  - LHU @0x0A -> 0x000080FF
  - LW @0x08 -> 0x80FF7F01
- Partial stores: after the above, SB wd=0x123456AA @0x09 and SH wd=0xDEADBEEF @0x0A, then LW @0x08 -> 0xBEEFAA01.
- Misalignment:
  - LW @0x06 -> rvalid=1, misalign=1, rd=0.
  - SH 0xFFFF @0x03, then LW @0x00 returns the prior value unchanged.
  - funct3=011 load -> misalign=1.
- Busy and reset mid-clear: assert rst at clear cycle 10 and release. busy stays high a full 32 cycles after release. req=1 throughout the clear yields no rvalid and no writes.
- Throughput: 4 consecutive LW requests on consecutive cycles -> 4 consecutive rvalid pulses, each one cycle after its request, in order.
